// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one I2C master engine among NREQ clients.
// A winner's addr/data/wr is latched, the master is launched with a run/busy
// handshake, and a one-cycle done/err response goes back to the winner.
// Optional watchdog: define I2C_TIMEOUT_EN to abort a master that never finishes.
module i2c_req_arbiter #(
  parameter int NREQ        = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,       // asynchronous, active-low
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_wr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  output logic              m_run,
  output logic [7:0]        m_addr,
  output logic [7:0]        m_data,
  output logic              m_wr_en,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_nack,
  output logic              m_abort
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Reject parameter sets the index arithmetic cannot represent.
  if (IDX_W != $clog2(NREQ) || NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("i2c_req_arbiter: inconsistent NREQ/IDX_W/TIMEOUT_CYC");
  end

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [7:0]       addr_reg, addr_next;
  logic [7:0]       data_reg, data_next;
  logic             wr_reg, wr_next;
  logic             err_reg, err_next;
  logic             expire;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  int               cand;

  // Round-robin search: first requester strictly after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(rr_ptr_reg) + k) % NREQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

`ifdef I2C_TIMEOUT_EN
  logic [31:0] timer_reg, timer_next;

  assign expire = (timer_reg == 32'(TIMEOUT_CYC - 1));

  // Watchdog: cleared on the way into LAUNCH, counts every LAUNCH/WAIT cycle.
  always_comb begin
    timer_next = timer_reg;
    if (state_reg == ST_GRANT)
      timer_next = '0;
    else if (state_reg == ST_LAUNCH || state_reg == ST_WAIT)
      timer_next = timer_reg + 32'd1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) timer_reg <= '0;
    else      timer_reg <= timer_next;
  end
`else
  assign expire = 1'b0;
`endif

  // FSM state and latched-operand registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      rr_ptr_reg <= IDX_W'(NREQ - 1);
      addr_reg   <= 8'h00;
      data_reg   <= 8'h00;
      wr_reg     <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      rr_ptr_reg <= rr_ptr_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      wr_reg     <= wr_next;
      err_reg    <= err_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    rr_ptr_next = rr_ptr_reg;
    addr_next   = addr_reg;
    data_next   = data_reg;
    wr_next     = wr_reg;
    err_next    = err_reg;
    busy        = 1'b0;
    m_run       = 1'b0;
    m_abort     = 1'b0;
    err         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          idx_next   = win_idx;
          addr_next  = req_addr[8*int'(win_idx) +: 8];
          data_next  = req_data[8*int'(win_idx) +: 8];
          wr_next    = req_wr[win_idx];
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        busy        = 1'b1;
        rr_ptr_next = idx_reg;
        err_next    = 1'b0;
        state_next  = ST_LAUNCH;
      end
      ST_LAUNCH, ST_WAIT: begin
        busy  = 1'b1;
        m_run = (state_reg == ST_LAUNCH);
        // A completing master beats a watchdog expiry on the same cycle.
        if (m_done) begin
          err_next   = m_nack;
          state_next = ST_RESP;
        end else if (expire) begin
          m_abort    = 1'b1;
          err_next   = 1'b1;
          state_next = ST_RESP;
        end else if (state_reg == ST_LAUNCH && m_busy) begin
          state_next = ST_WAIT;
        end
      end
      ST_RESP: begin
        busy       = 1'b1;
        err        = err_reg;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // One-hot grant and done pulses for the latched winner.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_client
    assign gnt[gi]  = (state_reg == ST_GRANT) && (idx_reg == IDX_W'(gi));
    assign done[gi] = (state_reg == ST_RESP)  && (idx_reg == IDX_W'(gi));
  end

  assign m_addr  = addr_reg;
  assign m_data  = data_reg;
  assign m_wr_en = wr_reg;

endmodule
